// File: rtl/mux_rr_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
package mux_rr_sel_arbiter_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_sel_arbiter_rr_prio_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod 4.
module rr_prio_pick4
    import mux_rr_sel_arbiter_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select; holds sel for a whole grant.
module mux_rr_sel_arbiter
    import mux_rr_sel_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CW       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             rel,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  gnt,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_d;
    logic [N_CH-1:0]  gnt_d;
    logic             busy_d;

    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             grant_exit;

    rr_prio_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel     <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
        end
    end

    // Next-state logic; any exit condition ends the grant exactly once.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        sel_d      = sel;
        gnt_d      = gnt;
        busy_d     = busy;
        grant_exit = rel || !req[sel] || (cnt_q == CW'(MAX_HOLD - 1));

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (any_req) begin
                    sel_d   = winner;
                    gnt_d   = N_CH'(1) << winner;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_exit) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel + SEL_W'(1);
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Scoreboard bench for mux_rr_sel_arbiter: directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_mux_rr_sel_arbiter;

    localparam int MAX_HOLD = 15;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";
    exp_t  expq[$];
    exp_t  mon_e;

    // Reference model state: current owner (-1 none), cycles held, next start channel.
    int m_owner, m_held, m_next, m_sel;

    mux_rr_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .rel   (rel),
        .sel   (sel),
        .gnt   (gnt),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_next  = 0;
        m_sel   = 0;
    endtask

    // Predict outputs after the coming edge given the inputs presented to it.
    task automatic model_step(input logic [3:0] r, input logic l);
        exp_t e;
        int   c;
        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_next + k) % 4;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_held = 1;
                m_sel  = m_owner;
            end
        end else if (l || !r[m_owner] || m_held == MAX_HOLD) begin
            m_next  = (m_owner + 1) % 4;
            m_owner = -1;
            m_held  = 0;
        end else begin
            m_held++;
        end
        e.sel  = 2'(m_sel);
        e.gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.busy = (m_owner >= 0);
        expq.push_back(e);
    endtask

    // Caller sits at a falling edge; present inputs, run one rising edge, return at next fall.
    task automatic cycle(input logic [3:0] r, input logic l);
        req = r;
        rel = l;
        model_step(r, l);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (sel !== 2'b00 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d gnt=%b busy=%b, want sel=0 gnt=0000 busy=0",
                     name, sel, gnt, busy);
        end
    endtask

    // Monitor: after every active edge out of reset, compare DUT outputs to the next prediction.
    always @(posedge clk) begin
        #1;
        if (rst_n && expq.size() > 0) begin
            mon_e = expq.pop_front();
            n_tests++;
            if ({sel, gnt, busy} !== mon_e) begin
                n_fail++;
                $display("FAIL %s: got sel=%0d gnt=%b busy=%b, want sel=%0d gnt=%b busy=%b",
                         phase, sel, gnt, busy, mon_e.sel, mon_e.gnt, mon_e.busy);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    logic [3:0] rnd_req;

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;
        model_reset();

        // Reset held while requests toggle: outputs stay cleared.
        phase = "reset_hold";
        #1 check_zero("reset_t0");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            #1 check_zero("reset_hold");
        end
        @(negedge clk);
        req   = 4'b1111;
        rst_n = 1'b1;
        phase = "reset_release";
        cycle(4'b1111, 1'b0);

        // Round-robin under full load with release one cycle after each grant.
        phase = "round_robin";
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1111, 1'b1);
            cycle(4'b1111, 1'b0);
        end
        cycle(4'b1111, 1'b1);

        // Skip and wrap: pointer at 3, only channel 1 requesting.
        phase = "skip_wrap";
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b1);
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b1);

        // Hold-time limit with a persistent single requester.
        phase = "timeout";
        for (int i = 0; i < 2 * MAX_HOLD + 4; i++) cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // Requester drop coinciding with release: single exit.
        phase = "drop_and_release";
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b1);

        // Release pulses while idle are ignored.
        phase = "idle_release";
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Asynchronous reset in the middle of a grant of channel 3.
        phase = "async_reset";
        cycle(4'b1000, 1'b0);
        cycle(4'b1000, 1'b0);
        #2;
        rst_n = 1'b0;
        req   = 4'b0000;
        #1 check_zero("async_reset_immediate");
        model_reset();
        @(negedge clk);
        check_zero("async_reset_held");
        rst_n = 1'b1;
        phase = "after_async_reset";
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b1);

        // Random traffic with sticky requests so timeouts and drops both occur.
        phase   = "random";
        rnd_req = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rnd_req = 4'($urandom);
            cycle(rnd_req, ($urandom_range(0, 5) == 0));
        end

        phase = "drain";
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending predictions, want 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_sel_arbiter.md
Name: mux_rr_sel_arbiter

Overview:
- Upstream control stage for the 4-input/1-output multiplexer.
- Arbitrates four request lines round-robin and drives the mux select with the winning channel index.
- Holds `sel` stable for the whole grant, so the mux output carries one source per transaction.
- A grant ends on explicit release, when the requester drops, or on a hold-time limit.

Parameters:
- MAX_HOLD, 15, maximum cycles a grant may last before forced release (legal range 1..(2**CW)-1).
- CW, 4, width of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request; req[i] set means channel i wants the mux.
- release  input  1  single-cycle pulse from the consumer ending the current grant.
- sel  output  2  registered mux select, wired to the mux select input.
- gnt  output  4  registered one-hot grant; gnt[sel] is set while granted.
- busy  output  1  registered; high while a grant is active.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, all of the following hold immediately, independent of clk:
  - sel=2'b00, gnt=4'b0000, busy=0
  - internal pointer ptr=2'b00
  - counter cnt=0
  - state=IDLE
- State machine has two states, IDLE and GRANT.
- IDLE, when req==0: outputs hold, sel keeps its last value, gnt=0, busy=0.
- IDLE, when req!=0 at a rising edge: the winner is the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). On that edge:
  - sel<=winner
  - gnt<=one-hot(winner)
  - busy<=1
  - cnt<=0
  - go to GRANT
  - Latency: request sampled at edge N, gnt/sel visible after edge N.
- GRANT: each edge with no exit condition does cnt<=cnt+1; sel and gnt hold.
- Exit conditions, evaluated at each edge in GRANT (any one suffices):
  - (a) release=1
  - (b) req[sel]=0
  - (c) cnt==MAX_HOLD-1
- On exit:
  - gnt<=0, busy<=0
  - ptr<=sel+1 (mod 4, 2'b11 wraps to 2'b00)
  - cnt<=0
  - go to IDLE
  - sel keeps the released value.
- Minimum one IDLE cycle between grants. No back-to-back grant on the exit edge, even if other requests are pending.
- Simultaneous exit conditions produce one exit only; ptr advances once.
- release in IDLE is ignored.
- req changes on non-selected channels during GRANT have no effect.
- With MAX_HOLD=1, a grant lasts exactly one cycle.
- Fairness: a channel requesting continuously is granted at least once every 4 grants.
- Reset asserted mid-grant clears everything asynchronously. The first grant after reset scans from channel 0.
- Width rules:
  - ptr and sel arithmetic is 2-bit with natural wrap.
  - cnt is CW bits and never exceeds MAX_HOLD-1.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=1'b0, GRANT=1'b1
  - channel count N_CH=4
  - select width SEL_W=2
- One natural sub-module, rr_prio_pick4: combinational; takes req[3:0] and ptr[1:0], returns winner[1:0] and any_req.
- The FSM, counter and output registers stay in mux_rr_sel_arbiter.
- Top-level integration instantiates mux_rr_sel_arbiter with sel driving the mux select.

Test Plan:
1. Reset check: hold rst_n=0, toggle req=4'b1111 -> sel=0, gnt=0, busy=0 throughout. Deassert rst_n with req=4'b1111 -> after the next edge, sel=0, gnt=4'b0001, busy=1.
2. Round-robin: req=4'b1111 held, release pulsed 1 cycle after each grant -> grant sequence is channels 0,1,2,3,0 with one busy=0 cycle between grants; sel matches each gnt index.
3. Skip and wrap: ptr=3 after granting channel 2, req=4'b0010 -> channel 1 granted (3 and 0 skipped), sel=2'b01, gnt=4'b0010.
4. Timeout: MAX_HOLD=15, req=4'b0100 held, no release -> gnt=4'b0100 for exactly 15 cycles, then busy=0 for one cycle, then channel 2 regranted.
5. Requester drop and simultaneity: during a grant of channel 1, drop req[1] and pulse release on the same edge -> single exit, ptr becomes 2. Next grant with req=4'b1111 goes to channel 2.
6. Async reset mid-grant: assert rst_n=0 between clock edges while gnt=4'b1000 -> gnt=0, busy=0, sel=0 immediately, before any edge. After release of reset, the next grant starts from channel 0.
